// File: rtl/interrupt_controller_if.sv
// Bundle of request-side and sequencer-side signals around the interrupt controller.
// The master side is the sequencer/decoder/peripherals and the slave side is the controller.
interface interrupt_controller_if #(
    parameter int N_IRQ = 4
);
    logic [N_IRQ-1:0] irq_req;
    logic [N_IRQ-1:0] irq_mask;
    logic             global_en;
    logic             seq_branch;
    logic [7:0]       next_addr;
    logic             reti;
    logic             irq_jmp;
    logic [3:0]       irq_vector;
    logic             ret_jmp;
    logic [7:0]       ret_addr;
    logic [N_IRQ-1:0] irq_pending;
    logic [N_IRQ-1:0] irq_active;
    logic             stack_err;

    modport master (
        output irq_req, irq_mask, global_en, seq_branch, next_addr, reti,
        input  irq_jmp, irq_vector, ret_jmp, ret_addr, irq_pending, irq_active, stack_err
    );

    modport slave (
        input  irq_req, irq_mask, global_en, seq_branch, next_addr, reti,
        output irq_jmp, irq_vector, ret_jmp, ret_addr, irq_pending, irq_active, stack_err
    );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritised, nestable interrupt scheduler: latches request edges, dispatches vectors,
// and keeps return addresses on a small hardware stack for RETI.

// Per-line edge detector and pending latch. A new edge wins over a same-cycle dispatch clear.
module irq_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    output logic pending
);
    logic req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            req_q <= req;
            if (req && !req_q)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end
endmodule

module interrupt_controller #(
    parameter int         N_IRQ       = 4,
    parameter int         STACK_DEPTH = 4,
    parameter logic [3:0] VECTOR_BASE = 4'h8
) (
    input  logic                  clk,
    input  logic                  async_reset_n,
    interrupt_controller_if.slave bus
);
    localparam int IW  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {READY, JUMP, RETURN} state_t;

    state_t           state;
    logic [N_IRQ-1:0] pending, active, clr;
    logic [7:0]       stack [STACK_DEPTH];
    logic [SPW-1:0]   sp, sp_m1;
    logic             irq_jmp, ret_jmp, stack_err;
    logic [3:0]       irq_vector;
    logic [7:0]       ret_addr;
    logic             cand_vld, act_vld, full, empty, disp;
    logic [IW-1:0]    cand_idx, act_idx;

    for (genvar i = 0; i < N_IRQ; i++) begin : g_lane
        irq_lane u_lane (
            .clk     (clk),
            .rst_n   (async_reset_n),
            .req     (bus.irq_req[i]),
            .clr     (clr[i]),
            .pending (pending[i])
        );
    end

    // Descending scan so the last hit is the lowest (highest-priority) index.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        act_vld  = 1'b0;
        act_idx  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && bus.irq_mask[i] && bus.global_en) begin
                cand_vld = 1'b1;
                cand_idx = IW'(i);
            end
            if (active[i]) begin
                act_vld = 1'b1;
                act_idx = IW'(i);
            end
        end
    end

    assign full  = (sp == SPW'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - SPW'(1);
    assign disp  = (state == READY) && cand_vld && (!act_vld || (cand_idx < act_idx)) &&
                   !full && !bus.seq_branch && !bus.reti;

    always_comb begin
        clr = '0;
        if (disp)
            clr[cand_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state      <= READY;
            active     <= '0;
            sp         <= '0;
            irq_jmp    <= 1'b0;
            irq_vector <= 4'h0;
            ret_jmp    <= 1'b0;
            ret_addr   <= 8'h00;
            stack_err  <= 1'b0;
            for (int k = 0; k < STACK_DEPTH; k++)
                stack[k] <= 8'h00;
        end else begin
            case (state)
                READY: begin
                    if (disp) begin
                        stack[sp[AW-1:0]] <= bus.next_addr;
                        sp                <= sp + SPW'(1);
                        active[cand_idx]  <= 1'b1;
                        irq_vector        <= VECTOR_BASE + 4'(cand_idx);
                        irq_jmp           <= 1'b1;
                        state             <= JUMP;
                    end else if (bus.reti) begin
                        if (!empty) begin
                            // Nesting only ever goes to lower indices, so the lowest active line is the newest.
                            ret_addr        <= stack[sp_m1[AW-1:0]];
                            sp              <= sp_m1;
                            active[act_idx] <= 1'b0;
                            ret_jmp         <= 1'b1;
                            state           <= RETURN;
                        end else begin
                            stack_err <= 1'b1;
                        end
                    end
                end
                JUMP: begin
                    irq_jmp <= 1'b0;
                    state   <= READY;
                end
                RETURN: begin
                    ret_jmp <= 1'b0;
                    state   <= READY;
                end
                default: state <= READY;
            endcase
        end
    end

    assign bus.irq_jmp     = irq_jmp;
    assign bus.irq_vector  = irq_vector;
    assign bus.ret_jmp     = ret_jmp;
    assign bus.ret_addr    = ret_addr;
    assign bus.irq_pending = pending;
    assign bus.irq_active  = active;
    assign bus.stack_err   = stack_err;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus a randomized run of the interrupt controller, checked against
// a queue-based model of the scheduling rules.
module tb_interrupt_controller;
    localparam int         NI    = 4;
    localparam int         DEPTH = 2;
    localparam logic [3:0] VBASE = 4'h8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    interrupt_controller_if #(.N_IRQ(NI)) bus ();

    interrupt_controller #(.N_IRQ(NI), .STACK_DEPTH(DEPTH), .VECTOR_BASE(VBASE)) dut (
        .clk           (clk),
        .async_reset_n (rst_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] addr;
    } frame_t;

    frame_t     m_stk[$];
    logic [3:0] m_pend, m_prev, m_vec;
    logic       m_jmp, m_ret, m_err;
    logic [7:0] m_raddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_active();
        logic [3:0] a = 4'h0;
        foreach (m_stk[k]) a[m_stk[k].idx] = 1'b1;
        return a;
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_pend  = '0;
        m_prev  = '0;
        m_vec   = '0;
        m_jmp   = 1'b0;
        m_ret   = 1'b0;
        m_err   = 1'b0;
        m_raddr = '0;
    endtask

    // One clock edge of the scheduling rules, using the inputs currently on the bus.
    task automatic model_step();
        bit         ready = !m_jmp && !m_ret;
        int         cand  = -1;
        logic [3:0] edges = bus.irq_req & ~m_prev;
        for (int i = 0; i < NI; i++)
            if (cand < 0 && m_pend[i] && bus.irq_mask[i] && bus.global_en) cand = i;
        m_jmp = 1'b0;
        m_ret = 1'b0;
        if (ready && bus.reti) begin
            if (m_stk.size() > 0) begin
                frame_t f = m_stk.pop_back();
                m_raddr = f.addr;
                m_ret   = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (ready && !bus.seq_branch && cand >= 0 && m_stk.size() < DEPTH &&
                     (m_stk.size() == 0 || cand < m_stk[$].idx)) begin
            m_stk.push_back('{cand, bus.next_addr});
            m_pend[cand] = 1'b0;
            m_vec        = 4'(int'(VBASE) + cand);
            m_jmp        = 1'b1;
        end
        m_pend = m_pend | edges;
        m_prev = bus.irq_req;
    endtask

    task automatic compare_all();
        check("irq_jmp",  {31'd0, bus.irq_jmp},   {31'd0, m_jmp});
        check("ret_jmp",  {31'd0, bus.ret_jmp},   {31'd0, m_ret});
        check("pending",  {28'd0, bus.irq_pending}, {28'd0, m_pend});
        check("active",   {28'd0, bus.irq_active},  {28'd0, m_active()});
        check("stack_err", {31'd0, bus.stack_err}, {31'd0, m_err});
        check("jmp_excl", {31'd0, bus.irq_jmp & bus.ret_jmp}, 32'd0);
        if (m_jmp) check("vector", {28'd0, bus.irq_vector}, {28'd0, m_vec});
        if (m_ret) check("ret_addr", {24'd0, bus.ret_addr}, {24'd0, m_raddr});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_reti();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.irq_req    = '0;
        bus.irq_mask   = 4'hF;
        bus.global_en  = 1'b1;
        bus.seq_branch = 1'b0;
        bus.next_addr  = 8'h23;
        bus.reti       = 1'b0;
        model_reset();
        #12;
        compare_all();
        check("rst_vector", {28'd0, bus.irq_vector}, 32'd0);
        check("rst_raddr",  {24'd0, bus.ret_addr},   32'd0);
        rst_n = 1'b1;

        // Basic dispatch and return
        tick();
        bus.irq_req = 4'b0100;
        tick();
        check("t1_pend", {28'd0, bus.irq_pending}, 32'b0100);
        tick();
        check("t1_jmp", {31'd0, bus.irq_jmp}, 32'd1);
        check("t1_vec", {28'd0, bus.irq_vector}, 32'hA);
        check("t1_act", {28'd0, bus.irq_active}, 32'b0100);
        bus.irq_req = '0;
        tick();
        check("t1_jmp_off", {31'd0, bus.irq_jmp}, 32'd0);
        pulse_reti();
        check("t1_ret", {31'd0, bus.ret_jmp}, 32'd1);
        check("t1_raddr", {24'd0, bus.ret_addr}, 32'h23);
        check("t1_act0", {28'd0, bus.irq_active}, 32'd0);
        tick();
        check("t1_ret_off", {31'd0, bus.ret_jmp}, 32'd0);

        // Nesting: 2 then 0, 3 waits for both returns
        bus.next_addr = 8'h40;
        bus.irq_req   = 4'b0100;
        tick();
        tick();
        check("t2_vecA", {28'd0, bus.irq_vector}, 32'hA);
        bus.next_addr = 8'h41;
        bus.irq_req   = 4'b0001;
        tick();
        tick();
        check("t2_jmp8", {31'd0, bus.irq_jmp}, 32'd1);
        check("t2_vec8", {28'd0, bus.irq_vector}, 32'h8);
        check("t2_act", {28'd0, bus.irq_active}, 32'b0101);
        bus.irq_req = 4'b1000;
        tick();
        tick();
        tick();
        check("t2_hold3", {31'd0, bus.irq_jmp}, 32'd0);
        check("t2_pend3", {28'd0, bus.irq_pending}, 32'b1000);
        pulse_reti();
        check("t2_raddr41", {24'd0, bus.ret_addr}, 32'h41);
        tick();
        tick();
        check("t2_still3", {31'd0, bus.irq_jmp}, 32'd0);
        pulse_reti();
        check("t2_raddr40", {24'd0, bus.ret_addr}, 32'h40);
        tick();
        tick();
        check("t2_vecB", {28'd0, bus.irq_vector}, 32'hB);
        check("t2_jmpB", {31'd0, bus.irq_jmp}, 32'd1);
        bus.irq_req = '0;
        tick();
        pulse_reti();
        tick();

        // Simultaneous edges: 1 before 3
        bus.irq_req = 4'b1010;
        tick();
        tick();
        check("t3_vec9", {28'd0, bus.irq_vector}, 32'h9);
        bus.irq_req = '0;
        tick();
        pulse_reti();
        tick();
        check("t3_blackout", {31'd0, bus.irq_jmp}, 32'd0);
        tick();
        check("t3_vecB", {28'd0, bus.irq_vector}, 32'hB);
        check("t3_jmpB", {31'd0, bus.irq_jmp}, 32'd1);
        tick();
        pulse_reti();
        tick();

        // Stack full at depth 2
        bus.irq_req = 4'b0100;
        tick();
        tick();
        bus.irq_req = 4'b0010;
        tick();
        tick();
        check("t4_act", {28'd0, bus.irq_active}, 32'b0110);
        bus.irq_req = 4'b0001;
        tick();
        tick();
        tick();
        check("t4_full", {31'd0, bus.irq_jmp}, 32'd0);
        pulse_reti();
        tick();
        tick();
        check("t4_vec8", {28'd0, bus.irq_vector}, 32'h8);
        check("t4_act2", {28'd0, bus.irq_active}, 32'b0101);
        bus.irq_req = '0;
        tick();
        pulse_reti();
        tick();
        pulse_reti();
        tick();

        // Empty-stack RETI and seq_branch hold
        pulse_reti();
        check("t5_noret", {31'd0, bus.ret_jmp}, 32'd0);
        check("t5_err", {31'd0, bus.stack_err}, 32'd1);
        bus.seq_branch = 1'b1;
        bus.irq_req    = 4'b0010;
        tick();
        tick();
        check("t5_held", {31'd0, bus.irq_jmp}, 32'd0);
        bus.seq_branch = 1'b0;
        tick();
        check("t5_vec9", {28'd0, bus.irq_vector}, 32'h9);
        check("t5_jmp", {31'd0, bus.irq_jmp}, 32'd1);
        bus.irq_req = '0;

        // Asynchronous reset during the JUMP cycle
        #2 rst_n = 1'b0;
        #1;
        check("t6_jmp", {31'd0, bus.irq_jmp}, 32'd0);
        check("t6_act", {28'd0, bus.irq_active}, 32'd0);
        check("t6_vec", {28'd0, bus.irq_vector}, 32'd0);
        check("t6_err", {31'd0, bus.stack_err}, 32'd0);
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
        tick();
        pulse_reti();
        check("t6_empty", {31'd0, bus.stack_err}, 32'd1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                #1 rst_n = 1'b1;
            end
            bus.irq_req    = bus.irq_req ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 9) == 0) bus.irq_mask = 4'($urandom);
            bus.global_en  = ($urandom_range(0, 15) != 0);
            bus.seq_branch = ($urandom_range(0, 3) == 0);
            bus.reti       = ($urandom_range(0, 5) == 0);
            bus.next_addr  = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
